// File: rtl/acsu_ctrl_213.sv
// acsu_ctrl_213 -- sequencing controller for the (2,1,3) Viterbi ACSU.
//
// Accepts hard-decision symbol pairs over a valid/ready handshake, forwards
// one pair per trellis step to the branch-metric logic, and pulses the ACSU
// enable. It watches the eight path metrics for normalisation, emits the
// survivor-memory write strobe/address two cycles after each acceptance, and
// starts traceback once the last survivor write has landed.
//
// Ports:
//   clock, reset      single clock, synchronous active-high reset
//   start             frame start request (honoured only when idle)
//   sym_valid/sym_in  received symbol pair; sym_ready is the handshake back
//   ppm_in            eight W-bit path metrics, state 0 in the low bits
//   rx_sym            registered symbol pair for the branch-metric unit
//   ae, ppm_init      ACSU step enable / initial-metric load
//   norm_en, norm_sub normalisation request and amount (valid with ae)
//   sm_wr_en/addr     survivor-memory write strobe and step address
//   tb_start/tb_done  traceback handoff
//   busy, done        frame in progress / one-cycle frame completion pulse
module acsu_ctrl_213 #(
    parameter int W  = 8,
    parameter int L  = 64,
    parameter int AW = 6
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           sym_valid,
    input  logic [1:0]     sym_in,
    output logic           sym_ready,
    input  logic [8*W-1:0] ppm_in,
    output logic [1:0]     rx_sym,
    output logic           ae,
    output logic           ppm_init,
    output logic           norm_en,
    output logic [W-1:0]   norm_sub,
    output logic           sm_wr_en,
    output logic [AW-1:0]  sm_wr_addr,
    output logic           tb_start,
    input  logic           tb_done,
    output logic           busy,
    output logic           done
);
    localparam int           CW      = AW + 1;
    localparam logic [CW-1:0] L_M1   = CW'(L - 1);
    localparam logic [CW-1:0] L_CNT  = CW'(L);
    localparam logic [W-1:0]  NORM_TH = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_RUN, S_DRAIN, S_TB, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] step_cnt, step_cnt_nxt;
    logic          drain_cnt;
    logic          tb_done_q;
    logic          norm_pending;
    logic [1:0]    vld_pipe;     // [0]: ACS step this cycle, [1]: its survivor write
    logic [AW-1:0] idx_q;        // step index travelling with vld_pipe[0]
    logic [W-1:0]  ppm_min;
    logic          accept, detect;
    logic          sym_ready_d, ae_d, ppm_init_d, norm_en_d;
    logic          tb_start_d, busy_d, done_d;

    assign accept   = sym_valid & sym_ready;
    assign sm_wr_en = vld_pipe[1];

    always_comb begin
        ppm_min = ppm_in[W-1:0];
        for (int i = 1; i < 8; i++)
            if (ppm_in[i*W +: W] < ppm_min) ppm_min = ppm_in[i*W +: W];
    end

    // Metrics seen during a norm_en cycle have not been reduced yet, so they
    // must not re-arm normalisation; INIT metrics are stale and also ignored.
    assign detect = ae & ~ppm_init & ~norm_en & (ppm_min >= NORM_TH);

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_INIT;
            S_INIT:  state_nxt = S_RUN;
            S_RUN:   if (accept && step_cnt == L_M1) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt) state_nxt = S_TB;
            // tb_done is registered first, so done lands two cycles after it
            S_TB:    if (tb_done_q) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // output logic: next values of the registered outputs
    always_comb begin
        step_cnt_nxt = step_cnt;
        if (state == S_INIT)  step_cnt_nxt = '0;
        else if (accept)      step_cnt_nxt = step_cnt + 1'b1;
        sym_ready_d = (state_nxt == S_RUN) && (step_cnt_nxt < L_CNT);
        ae_d        = (state_nxt == S_INIT) || accept;
        ppm_init_d  = (state_nxt == S_INIT);
        norm_en_d   = accept && (norm_pending || detect);
        tb_start_d  = (state_nxt == S_TB) && (state != S_TB);
        busy_d      = (state_nxt != S_IDLE);
        done_d      = (state_nxt == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            step_cnt     <= '0;
            drain_cnt    <= 1'b0;
            tb_done_q    <= 1'b0;
            norm_pending <= 1'b0;
            norm_sub     <= '0;
            vld_pipe     <= '0;
            idx_q        <= '0;
            rx_sym       <= '0;
            sm_wr_addr   <= '0;
            sym_ready    <= 1'b0;
            ae           <= 1'b0;
            ppm_init     <= 1'b0;
            norm_en      <= 1'b0;
            tb_start     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            step_cnt  <= step_cnt_nxt;
            drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
            tb_done_q <= (state == S_TB) & tb_done;

            if (state == S_INIT)  norm_pending <= 1'b0;
            else if (detect)      norm_pending <= 1'b1;
            else if (norm_en)     norm_pending <= 1'b0;
            if (detect) norm_sub <= NORM_TH;

            vld_pipe <= {vld_pipe[0], accept};
            if (accept) begin
                idx_q  <= step_cnt[AW-1:0];
                rx_sym <= sym_in;
            end
            if (state == S_INIT)   sm_wr_addr <= '0;
            else if (vld_pipe[0])  sm_wr_addr <= idx_q;

            sym_ready <= sym_ready_d;
            ae        <= ae_d;
            ppm_init  <= ppm_init_d;
            norm_en   <= norm_en_d;
            tb_start  <= tb_start_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end
endmodule

// File: tb/tb_acsu_ctrl_213.sv
// Bench for acsu_ctrl_213: directed frames (full rate, throttled with
// normalisation, reset mid-frame) checked every cycle against a
// timestamp/schedule model of the controller's observable behaviour.
module tb_acsu_ctrl_213;
    localparam int W = 8, L = 64, AW = 6, MAXC = 8192, INF = 1000000;

    logic           clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic           sym_valid = 1'b0, tb_done = 1'b0;
    logic [1:0]     sym_in = '0;
    logic [8*W-1:0] ppm_in;
    logic           sym_ready, ae, ppm_init, norm_en, sm_wr_en, tb_start, busy, done;
    logic [1:0]     rx_sym;
    logic [W-1:0]   norm_sub;
    logic [AW-1:0]  sm_wr_addr;

    acsu_ctrl_213 #(.W(W), .L(L), .AW(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .sym_valid(sym_valid),
        .sym_in(sym_in), .sym_ready(sym_ready), .ppm_in(ppm_in), .rx_sym(rx_sym),
        .ae(ae), .ppm_init(ppm_init), .norm_en(norm_en), .norm_sub(norm_sub),
        .sm_wr_en(sm_wr_en), .sm_wr_addr(sm_wr_addr), .tb_start(tb_start),
        .tb_done(tb_done), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // model: per-cycle expected pulses plus frame timestamps
    bit e_ae[MAXC], e_init[MAXC], e_nrm[MAXC], e_wr[MAXC], e_tbs[MAXC], e_done[MAXC];
    int e_rx[MAXC], e_addr[MAXC];
    int t_start = -1, t_last = INF, t_tbd = INF, cnt = 0;
    bit pending = 0;
    int obs_ae = 0, obs_wr = 0, obs_nrm = 0, obs_last_addr = -1;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    function automatic bit busy_m(input int c);
        return t_start >= 0 && c > t_start && c <= t_tbd + 2;
    endfunction
    function automatic bit rdy_m(input int c);
        return t_start >= 0 && c >= t_start + 2 && c <= t_last;
    endfunction
    function automatic bit in_tb(input int c);
        return t_start >= 0 && t_last != INF && c >= t_last + 3 && t_tbd == INF;
    endfunction
    function automatic int ppm_min_m();
        int m = 1 << W;
        for (int i = 0; i < 8; i++) if (int'(ppm_in[i*W +: W]) < m) m = int'(ppm_in[i*W +: W]);
        return m;
    endfunction
    function automatic logic [8*W-1:0] ppm_all(input int v);
        logic [8*W-1:0] r;
        for (int i = 0; i < 8; i++) r[i*W +: W] = W'(v);
        return r;
    endfunction

    always @(negedge clock) begin
        int n;
        n = cyc;
        if (n >= 1) begin
            chk("ae", ae, e_ae[n]);
            chk("ppm_init", ppm_init, e_init[n]);
            chk("norm_en", norm_en, e_nrm[n]);
            chk("sm_wr_en", sm_wr_en, e_wr[n]);
            chk("tb_start", tb_start, e_tbs[n]);
            chk("done", done, e_done[n]);
            chk("busy", busy, busy_m(n));
            chk("sym_ready", sym_ready, rdy_m(n));
            if (e_ae[n] && !e_init[n]) chk("rx_sym", rx_sym, e_rx[n]);
            if (e_wr[n]) chk("sm_wr_addr", sm_wr_addr, e_addr[n]);
            if (e_nrm[n]) chk("norm_sub", norm_sub, 1 << (W-1));
            if (ae && !ppm_init) obs_ae++;
            if (sm_wr_en) begin obs_wr++; obs_last_addr = int'(sm_wr_addr); end
            if (norm_en) obs_nrm++;
        end
        // advance model with this cycle's inputs
        if (reset) begin
            t_start = -1; t_last = INF; t_tbd = INF; cnt = 0; pending = 0;
            for (int c = n + 1; c <= n + 3; c++) begin
                e_ae[c] = 0; e_init[c] = 0; e_nrm[c] = 0;
                e_wr[c] = 0; e_tbs[c] = 0; e_done[c] = 0;
            end
        end else begin
            if (e_ae[n] && !e_init[n] && !e_nrm[n] && ppm_min_m() >= (1 << (W-1)))
                pending = 1;
            if (start && !busy_m(n)) begin
                t_start = n; t_last = INF; t_tbd = INF; cnt = 0; pending = 0;
                e_ae[n+1] = 1; e_init[n+1] = 1;
            end else if (rdy_m(n) && sym_valid) begin
                e_ae[n+1] = 1; e_rx[n+1] = int'(sym_in);
                e_nrm[n+1] = pending; pending = 0;
                e_wr[n+2] = 1; e_addr[n+2] = cnt % (1 << AW);
                if (cnt == L - 1) begin t_last = n; e_tbs[n+3] = 1; end
                cnt++;
            end
            if (in_tb(n) && tb_done) begin t_tbd = n; e_done[n+2] = 1; end
        end
    end

    task automatic step();
        @(posedge clock); #1;
    endtask

    // sel 0: tb_start, sel 1: done; bounded
    task automatic wait_for(input int sel, input int maxc);
        bit hit = 0;
        for (int i = 0; i < maxc && !hit; i++) begin
            if ((sel == 0 && tb_start === 1'b1) || (sel == 1 && done === 1'b1)) hit = 1;
            else step();
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL wait_%s timed out after %0d cycles", sel == 0 ? "tb_start" : "done", maxc);
        end
    endtask

    // full-rate symbols until sym_ready drops, then one more DRAIN cycle with valid high
    task automatic run_full(input bit junk);
        sym_valid = 1;
        for (int i = 0; i < 200; i++) begin
            sym_in  = 2'(i * 3 + 1);
            start   = junk && (i == 20);
            tb_done = junk && (i == 30);
            step();
            if (i > 2 && !sym_ready) break;
        end
        start = 0; tb_done = 0;
        step();
        sym_valid = 0;
    endtask

    task automatic zero_lits(input string tag);
        chk({tag, "_ae"}, ae, 0);         chk({tag, "_init"}, ppm_init, 0);
        chk({tag, "_nrm"}, norm_en, 0);   chk({tag, "_wr"}, sm_wr_en, 0);
        chk({tag, "_tbs"}, tb_start, 0);  chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);     chk({tag, "_rdy"}, sym_ready, 0);
        chk({tag, "_rx"}, rx_sym, 0);     chk({tag, "_addr"}, sm_wr_addr, 0);
        chk({tag, "_nsub"}, norm_sub, 0);
    endtask

    initial begin
        ppm_in = ppm_all(10);
        step(); step(); step();
        reset = 0;
        zero_lits("rst0");

        // frame A: full rate, stray start/tb_done during RUN and start in TB
        step(); start = 1; step(); start = 0;
        chk("A_init_ae", ae, 1); chk("A_init_pi", ppm_init, 1);
        obs_ae = 0; obs_wr = 0; obs_nrm = 0;
        run_full(1);
        wait_for(0, 10);
        start = 1; step(); start = 0; step(); step();
        tb_done = 1; step(); tb_done = 0; step();
        chk("A_done_lit", done, 1);
        start = 1; step();                 // start during DONE: ignored
        step(); start = 0;                 // start in IDLE: frame B INIT now
        chk("B_init_ae", ae, 1); chk("B_init_pi", ppm_init, 1);
        chk("A_ae_cnt", obs_ae, 64); chk("A_wr_cnt", obs_wr, 64);
        chk("A_last_addr", obs_last_addr, 63);
        obs_ae = 0; obs_wr = 0; obs_nrm = 0;

        // frame B: throttled 1,0,0 pattern; metrics 130 after step 5, min 127 after step 10
        for (int j = 0; j < L; j++) begin
            step(); sym_valid = 1; sym_in = 2'(j * 5 + 2);
            step(); sym_valid = 0;
            if (j == 5) ppm_in = ppm_all(130);
            if (j == 10) begin ppm_in = ppm_all(200); ppm_in[3*W +: W] = 8'd127; end
            step(); ppm_in = ppm_all(10);
        end
        wait_for(0, 10);
        tb_done = 1; step(); tb_done = 0;
        wait_for(1, 10);
        chk("B_nrm_cnt", obs_nrm, 1); chk("B_ae_cnt", obs_ae, 64);
        chk("B_first_addr_restart", obs_last_addr, 63);

        // frame C: abandoned by a 3-cycle reset mid-RUN
        step(); step(); start = 1; step(); start = 0;
        sym_valid = 1;
        for (int i = 0; i < 10; i++) begin sym_in = 2'(i); step(); end
        reset = 1; step(); step(); step();
        reset = 0; sym_valid = 0;
        zero_lits("rst1");
        step(); step();

        // frame D: fresh start after reset
        start = 1; step(); start = 0;
        chk("D_init_ae", ae, 1); chk("D_init_pi", ppm_init, 1);
        run_full(0);
        wait_for(0, 10);
        step(); tb_done = 1; step(); tb_done = 0;
        wait_for(1, 10);
        step(); step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/acsu_ctrl_213.md
# acsu_ctrl_213

Sequencing controller for the (2,1,3) Viterbi add-compare-select unit. Accepts received hard-decision symbol pairs over a valid/ready handshake, forwards one pair per trellis step to the branch-metric logic, and drives the ACSU enable and path-metric initialisation. It monitors the eight path metrics for normalisation, generates survivor-memory write strobes and addresses, and hands off to traceback at the end of each frame. It sits between the symbol input stage and the branch-metric unit, the ACSU, the survivor memory and the traceback unit.

## Interface
- W, 8, path-metric width; matches the ACSU metric width
- L, 64, trellis steps per frame, including the 2 tail steps; 3..2^AW
- AW, 6, survivor-memory address width
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle frame start request; ignored unless in IDLE
- sym_valid  in  1  received symbol pair valid
- sym_in  in  2  received hard-decision symbol pair
- sym_ready  out  1  controller can accept a symbol this cycle
- ppm_in  in  8*W  the eight ACSU path metrics, state 0 in bits [W-1:0]
- rx_sym  out  2  registered symbol pair to branch-metric logic
- ae  out  1  ACSU enable: the ACSU updates on the rising edge ending this cycle
- ppm_init  out  1  with ae: load initial metrics (state 0 = 0, others = 2^(W-2))
- norm_en  out  1  with ae: ACSU subtracts norm_sub from every new metric
- norm_sub  out  W  normalisation amount
- sm_wr_en  out  1  survivor-memory write strobe for the ACSU decision bits
- sm_wr_addr  out  AW  survivor-memory write address
- tb_start  out  1  one-cycle pulse to start traceback
- tb_done  in  1  traceback complete
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame completion

## Operation
- All outputs are registered. Reset value of every output is 0. Reset drives the FSM to IDLE and clears step_cnt and norm_pending.
- IDLE: sym_ready=0. On start, go to INIT.
- INIT (1 cycle): ae=1 and ppm_init=1. step_cnt cleared. Go to RUN.
- RUN: sym_ready=1 while step_cnt < L. A symbol is accepted when sym_valid and sym_ready are both high; each acceptance increments step_cnt.
  - When step_cnt reaches L, sym_ready deasserts in the same cycle as the last acceptance is registered. Go to DRAIN.
- DRAIN (2 cycles): waits for the last survivor write, then goes to TB.
- TB: tb_start pulses for 1 cycle on entry. Remain in TB until tb_done is high, then go to DONE.
- DONE (1 cycle): done=1, then go to IDLE.
- Normalisation:
  - On every ae cycle the controller computes m = min(ppm_in[0..7]), combinationally.
  - If m >= 2^(W-1), it sets norm_pending and latches norm_sub = 2^(W-1).
  - On the next ae cycle, norm_en=1 and norm_pending clears.
  - norm_en is never asserted with ppm_init. A pending normalisation is dropped on INIT.
- Survivor addressing:
  - sm_wr_addr = step index of the decisions being written, counted modulo 2^AW.
  - The address restarts at 0 on every INIT.
- sym_valid with sym_ready low: the symbol is not consumed and has no effect.
- start outside IDLE: ignored.
- tb_done outside TB: ignored.
- Reset mid-frame: abandons the frame. No done pulse and no tb_start are produced.

## Timing
- A symbol accepted in cycle t gives:
  - rx_sym valid in cycle t+1 and ae=1 in cycle t+1;
  - sm_wr_en=1 in cycle t+2, with sm_wr_addr = step index (0 for the first symbol).
- Back-to-back acceptance gives one ACS step per cycle, so full throughput is 1 symbol/cycle.
- ae is 0 on every cycle that has no acceptance in the previous cycle, except the INIT cycle.
- INIT is 1 cycle, so the earliest acceptance is in the cycle after INIT.
- From the last acceptance (cycle t): the last sm_wr_en is in t+2 and tb_start is in t+3.
- done occurs 2 cycles after the cycle in which tb_done is sampled high.
- Minimum frame length in cycles: 1 (INIT) + L + 2 (DRAIN) + TB duration + 1 (DONE).

## Test plan
- Reset/idle: assert reset for 3 cycles mid-RUN. Required: all outputs 0, busy=0, FSM in IDLE; the next start begins with INIT (ae=1, ppm_init=1).
- Full-rate frame, L=64, sym_valid held high:
  - exactly 64 ae pulses after the INIT pulse;
  - sm_wr_addr runs 0..63, each write lagging its ae by 1 cycle;
  - tb_start 1 cycle after the last write; done 2 cycles after tb_done.
- Throttled input, sym_valid toggling 1,0,0,1:
  - ae follows each acceptance by exactly 1 cycle;
  - rx_sym matches sym_in at each acceptance;
  - no ae pulses in the gaps.
- Normalisation, W=8:
  - force all ppm_in = 130 on an ae cycle; the next ae has norm_en=1 and norm_sub=128;
  - min = 127 produces no norm_en.
- Illegal/overlap events:
  - start pulsed during RUN and during TB has no effect;
  - tb_done pulsed during RUN has no effect;
  - sym_valid during DRAIN is not accepted (sym_ready=0).
- Back-to-back frames: start during the DONE cycle is ignored; start in the following IDLE cycle begins a new frame with sm_wr_addr restarting at 0.
